// File: rtl/comparator_h.sv
// comparator_h
// Horizontal-sync comparator for the VGA-style timing path. The horizontal
// pixel counter is compared against the sync-pulse width to produce the
// horizontal sync level. A combinational version is available immediately,
// and a registered copy with one-cycle start/end strobes is provided for
// downstream logic running on the pixel clock.
//
// Parameters:
//   N          - counter MSB index (countH is N+1 bits wide)
//   SYNC_WIDTH - number of counter values, starting at 0, with the pulse active
//   SYNC_POL   - active level of the sync pulse (0 = active-low)
//
// Ports:
//   clk        - pixel clock, rising edge
//   rst        - asynchronous active-high reset
//   countH     - horizontal counter value, unsigned
//   sync       - combinational sync level
//   sync_q     - sync registered on clk
//   sync_start - one-cycle strobe when sync_q becomes active
//   sync_end   - one-cycle strobe when sync_q becomes inactive
module comparator_h #(
    parameter int N          = 7,
    parameter int SYNC_WIDTH = 96,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [N:0] countH,
    output logic       sync,
    output logic       sync_q,
    output logic       sync_start,
    output logic       sync_end
);

    localparam logic        ACTIVE_LEVEL = SYNC_POL;
    // Treating the width as an unsigned 32-bit value makes a width of 0
    // never match and any width beyond the counter range always match.
    localparam logic [31:0] WIDTH_U      = SYNC_WIDTH;

    logic [31:0] w_countExt;
    logic        w_pulseActive;
    logic        r_syncQ;
    logic        r_syncStart;
    logic        r_syncEnd;

    assign w_countExt    = 32'(countH);
    assign w_pulseActive = (w_countExt < WIDTH_U);
    assign sync          = w_pulseActive ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;

    // Strobes compare the value about to be loaded into sync_q with the
    // current one, so they line up with the cycle sync_q changes. Reset
    // parks sync_q at the inactive level, which means no end strobe can
    // ever come out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_syncQ     <= ~ACTIVE_LEVEL;
            r_syncStart <= 1'b0;
            r_syncEnd   <= 1'b0;
        end else begin
            r_syncQ     <= sync;
            r_syncStart <= (sync == ACTIVE_LEVEL) && (r_syncQ != ACTIVE_LEVEL);
            r_syncEnd   <= (sync != ACTIVE_LEVEL) && (r_syncQ == ACTIVE_LEVEL);
        end
    end

    assign sync_q     = r_syncQ;
    assign sync_start = r_syncStart;
    assign sync_end   = r_syncEnd;

endmodule

// File: tb/tb_comparator_h.sv
// tb_comparator_h
// Directed bench for comparator_h. One instance uses the default active-low
// 96-wide pulse; a second instance uses an active-high 10-wide pulse.
module tb_comparator_h;

    logic       clk;
    logic       rst;
    logic [7:0] countH;
    logic [7:0] countH2;
    logic       sync, syncQ, syncStart, syncEnd;
    logic       sync2, syncQ2, syncStart2, syncEnd2;

    int checks = 0;
    int errors = 0;

    comparator_h dut (
        .clk        (clk),
        .rst        (rst),
        .countH     (countH),
        .sync       (sync),
        .sync_q     (syncQ),
        .sync_start (syncStart),
        .sync_end   (syncEnd)
    );

    comparator_h #(.N(7), .SYNC_WIDTH(10), .SYNC_POL(1'b1)) dutPos (
        .clk        (clk),
        .rst        (rst),
        .countH     (countH2),
        .sync       (sync2),
        .sync_q     (syncQ2),
        .sync_start (syncStart2),
        .sync_end   (syncEnd2)
    );

    // Pixel clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the default instance's counter and let the comb path settle.
    task automatic applyStimulus(input logic [7:0] value);
        countH = value;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    logic expQ;
    logic prevQ;
    logic expStart;
    logic expEnd;
    int   lowCount;
    int   startCount;
    int   endCount;

    initial begin
        rst     = 1'b1;
        countH  = 8'd0;
        countH2 = 8'd0;
        #12;

        // Reset state of both instances
        checkOutput("rst_syncq",     32'(syncQ),     32'd1);
        checkOutput("rst_start",     32'(syncStart), 32'd0);
        checkOutput("rst_end",       32'(syncEnd),   32'd0);
        checkOutput("rst_syncq_pos", 32'(syncQ2),    32'd0);
        checkOutput("rst_sync_comb", 32'(sync),      32'd0);

        // Release reset between edges with countH=0 (active): start pulses
        rst = 1'b0;
        applyStimulus(8'd0);
        checkOutput("c0_sync", 32'(sync), 32'd0);
        stepClock();
        checkOutput("c0_syncq", 32'(syncQ),     32'd0);
        checkOutput("c0_start", 32'(syncStart), 32'd1);
        checkOutput("c0_end",   32'(syncEnd),   32'd0);

        applyStimulus(8'd50);
        checkOutput("c50_sync", 32'(sync), 32'd0);
        stepClock();
        checkOutput("c50_syncq", 32'(syncQ),     32'd0);
        checkOutput("c50_start", 32'(syncStart), 32'd0);

        // Leaving the pulse region: end strobe for exactly one cycle
        applyStimulus(8'd100);
        checkOutput("c100_sync", 32'(sync), 32'd1);
        stepClock();
        checkOutput("c100_syncq", 32'(syncQ),     32'd1);
        checkOutput("c100_end",   32'(syncEnd),   32'd1);
        checkOutput("c100_start", 32'(syncStart), 32'd0);
        stepClock();
        checkOutput("c100_end2",  32'(syncEnd),   32'd0);
        checkOutput("c100_syncq2", 32'(syncQ),    32'd1);

        // Comparison boundaries
        applyStimulus(8'd95);
        checkOutput("b95_sync", 32'(sync), 32'd0);
        applyStimulus(8'd96);
        checkOutput("b96_sync", 32'(sync), 32'd1);
        applyStimulus(8'd255);
        checkOutput("b255_sync", 32'(sync), 32'd1);
        stepClock();
        checkOutput("b255_syncq", 32'(syncQ), 32'd1);

        // Free-running counter, two laps starting from sync_q inactive
        prevQ = 1'b1;
        for (int lap = 0; lap < 2; lap++) begin
            lowCount   = 0;
            startCount = 0;
            endCount   = 0;
            for (int c = 0; c < 256; c++) begin
                applyStimulus(8'(c));
                expQ     = (c < 96) ? 1'b0 : 1'b1;
                expStart = (expQ == 1'b0) && (prevQ == 1'b1);
                expEnd   = (expQ == 1'b1) && (prevQ == 1'b0);
                checkOutput("run_sync", 32'(sync), 32'(expQ));
                stepClock();
                checkOutput("run_syncq", 32'(syncQ),     32'(expQ));
                checkOutput("run_start", 32'(syncStart), 32'(expStart));
                checkOutput("run_end",   32'(syncEnd),   32'(expEnd));
                if (syncQ == 1'b0) lowCount++;
                if (syncStart) startCount++;
                if (syncEnd) endCount++;
                prevQ = expQ;
            end
            checkOutput("lap_low",    32'(lowCount),   32'd96);
            checkOutput("lap_starts", 32'(startCount), 32'd1);
            checkOutput("lap_ends",   32'(endCount),   32'd1);
        end

        // Reset asserted mid-pulse, between edges
        applyStimulus(8'd40);
        stepClock();
        checkOutput("mid_syncq", 32'(syncQ),     32'd0);
        checkOutput("mid_start", 32'(syncStart), 32'd1);
        stepClock();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_syncq", 32'(syncQ),     32'd1);
        checkOutput("mid_rst_start", 32'(syncStart), 32'd0);
        checkOutput("mid_rst_end",   32'(syncEnd),   32'd0);
        checkOutput("mid_rst_sync",  32'(sync),      32'd0);
        stepClock();
        checkOutput("mid_hold_syncq", 32'(syncQ),   32'd1);
        checkOutput("mid_hold_end",   32'(syncEnd), 32'd0);
        rst = 1'b0;
        stepClock();
        checkOutput("rel_syncq", 32'(syncQ),     32'd0);
        checkOutput("rel_start", 32'(syncStart), 32'd1);
        checkOutput("rel_end",   32'(syncEnd),   32'd0);

        // Active-high, 10-wide instance
        countH2 = 8'd9;
        #1;
        checkOutput("pos_c9_sync", 32'(sync2), 32'd1);
        countH2 = 8'd10;
        #1;
        checkOutput("pos_c10_sync", 32'(sync2), 32'd0);
        countH2 = 8'd255;
        #1;
        checkOutput("pos_c255_sync", 32'(sync2), 32'd0);
        stepClock();
        checkOutput("pos_c255_syncq", 32'(syncQ2),   32'd0);
        checkOutput("pos_c255_end",   32'(syncEnd2), 32'd1);
        countH2 = 8'd5;
        #1;
        checkOutput("pos_c5_sync", 32'(sync2), 32'd1);
        stepClock();
        checkOutput("pos_c5_syncq", 32'(syncQ2),     32'd1);
        checkOutput("pos_c5_start", 32'(syncStart2), 32'd1);
        checkOutput("pos_c5_end",   32'(syncEnd2),   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
